// File: rtl/image_stream_loader.sv
// image_stream_loader: receives one label beat followed by IMAGE_SIZE*IMAGE_SIZE
// pixel beats on a valid/ready byte stream and assembles them into the flattened,
// row-major image vector that the convolution layer consumes. It uses the same
// en/done handshake as the layer blocks.
//
// Optional feature: define LOADER_CHECKSUM_EN to add a trailing checksum beat.
// That beat is the modulo-2^PIXEL_DEPTH sum of all pixel beats. s_last is then
// expected on the checksum beat instead of on the final pixel.
//
// Ports:
//   clk, rst  clock; asynchronous active-high reset
//   en        level-sensitive start/hold from the sequencer
//   s_valid   stream beat valid
//   s_data    stream beat payload (label or pixel)
//   s_last    marks the final beat of a frame
//   s_ready   loader can accept a beat (registered)
//   o_image   flattened image; pixel p at [(p+1)*PIXEL_DEPTH-1 -: PIXEL_DEPTH]
//   o_label   captured label (low LABEL_DEPTH bits of the label beat, zero-extended)
//   done      frame complete; held until en drops
//   err       framing or checksum error for the current frame
module image_stream_loader #(
   parameter int unsigned IMAGE_SIZE  = 28,
   parameter int unsigned PIXEL_DEPTH = 8,
   parameter int unsigned LABEL_DEPTH = 8
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       en,
   input  logic                                       s_valid,
   input  logic [PIXEL_DEPTH-1:0]                     s_data,
   input  logic                                       s_last,
   output logic                                       s_ready,
   output logic [IMAGE_SIZE*IMAGE_SIZE*PIXEL_DEPTH-1:0] o_image,
   output logic [LABEL_DEPTH-1:0]                     o_label,
   output logic                                       done,
   output logic                                       err
);

   localparam int unsigned NUM_PIXELS = IMAGE_SIZE * IMAGE_SIZE;
   localparam int unsigned CNT_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_PIXELS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LABEL  = 3'd1,
      PIXELS = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      CHECK  = 3'd3,
`endif
      DONE   = 3'd4
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic             xfer;
   logic             last_slot;
   logic             ready_nxt;
   logic             done_nxt;
`ifdef LOADER_CHECKSUM_EN
   logic [PIXEL_DEPTH-1:0] sum;
`endif

   assign xfer      = s_valid && s_ready;
   assign last_slot = (cnt == LAST_SLOT);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic; dropping en aborts any in-progress frame.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (en) next_state = LABEL;
         LABEL: begin
            if (!en)       next_state = IDLE;
            else if (xfer) next_state = s_last ? DONE : PIXELS;
         end
         PIXELS: begin
            if (!en) next_state = IDLE;
`ifdef LOADER_CHECKSUM_EN
            else if (xfer && last_slot) next_state = CHECK;
            else if (xfer && s_last)    next_state = DONE;
`else
            else if (xfer && (last_slot || s_last)) next_state = DONE;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (!en)       next_state = IDLE;
            else if (xfer) next_state = DONE;
         end
`endif
         DONE:    if (!en) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode. done lags entry into DONE by one edge and falls together with en.
   always_comb begin
      ready_nxt = 1'b0;
      done_nxt  = 1'b0;
      case (next_state)
         LABEL, PIXELS: ready_nxt = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         CHECK:         ready_nxt = 1'b1;
`endif
         default:       ready_nxt = 1'b0;
      endcase
      done_nxt = (state == DONE) && en;
   end

   // Registered outputs and datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ready <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         o_image <= '0;
         o_label <= '0;
         cnt     <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum     <= '0;
`endif
      end else begin
         s_ready <= ready_nxt;
         done    <= done_nxt;
         case (state)
            IDLE: begin
               if (en) begin
                  o_image <= '0;
                  o_label <= '0;
                  err     <= 1'b0;
                  cnt     <= '0;
`ifdef LOADER_CHECKSUM_EN
                  sum     <= '0;
`endif
               end
            end
            LABEL: begin
               if (en && xfer) begin
                  o_label <= LABEL_DEPTH'(s_data);
                  if (s_last) err <= 1'b1;
               end
            end
            PIXELS: begin
               if (en && xfer) begin
                  // Decoded write keeps every slice index constant.
                  for (int unsigned p = 0; p < NUM_PIXELS; p++) begin
                     if (CNT_W'(p) == cnt) o_image[p*PIXEL_DEPTH +: PIXEL_DEPTH] <= s_data;
                  end
                  // Counter saturates on the final slot so it can never wrap.
                  if (!last_slot) cnt <= cnt + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                  sum <= sum + s_data;
                  if (!last_slot && s_last) err <= 1'b1;
`else
                  if (last_slot ? !s_last : s_last) err <= 1'b1;
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (en && xfer) begin
                  if ((s_data != sum) || !s_last) err <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed self-checking bench for image_stream_loader (default build).
module tb_image_stream_loader;
   localparam int unsigned IS = 28;
   localparam int unsigned PD = 8;
   localparam int unsigned LD = 8;
   localparam int unsigned NP = IS * IS;

   logic clk = 1'b0;
   logic rst, en, s_valid, s_last, s_ready, done, err;
   logic [PD-1:0]    s_data;
   logic [NP*PD-1:0] o_image;
   logic [LD-1:0]    o_label;

   image_stream_loader #(.IMAGE_SIZE(IS), .PIXEL_DEPTH(PD), .LABEL_DEPTH(LD)) dut (
      .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .o_image(o_image), .o_label(o_label),
      .done(done), .err(err));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state: expected handshake outputs and the image the frame should leave behind.
   logic          chk_on    = 1'b0;
   logic          exp_ready = 1'b0;
   logic          exp_done  = 1'b0;
   logic          exp_err   = 1'b0;
   logic [PD-1:0] exp_pix [NP];
   logic [LD-1:0] exp_label;

   task automatic check(input string name, input longint act, input longint req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_image(input string name);
      int bad = -1;
      for (int p = 0; p < NP; p++) begin
         if (o_image[p*PD +: PD] !== exp_pix[p]) begin
            bad = p;
            break;
         end
      end
      n_chk++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: pixel %0d got %0h, expected %0h", name, bad,
                  o_image[bad*PD +: PD], exp_pix[bad]);
      end
   endtask

   function automatic logic [PD-1:0] pix(input int p);
      return o_image[p*PD +: PD];
   endfunction

   // Per-cycle comparison of the handshake outputs against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("s_ready", s_ready, exp_ready);
         check("done", done, exp_done);
         check("err", err, exp_err);
      end
   end

   // Sends one frame: label, then pixels p%256. last_at = pixel index carrying s_last
   // (-1 for none); toggle = s_valid alternates 1/0; abort_after = drop en after that
   // many pixels (-1 for none). done_cyc = edges from start edge to done (-1 if absent).
   task automatic send_frame(input logic [7:0] label, input int last_at, input bit toggle,
                             input int abort_after, output int done_cyc);
      int  b = 0;
      int  start_c;
      bit  ph = 1'b0;
      bit  fin = 1'b0;
      bit  lst;
      done_cyc = -1;
      en = 1'b1;
      @(posedge clk); #1;
      start_c = cyc;
      exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0; exp_label = '0;
      for (int p = 0; p < NP; p++) exp_pix[p] = '0;
      while (!fin) begin
         lst     = (b > 0) && (b - 1 == last_at);
         s_valid = toggle ? ~ph : 1'b1;
         ph      = ~ph;
         s_data  = (b == 0) ? PD'(label) : PD'(b - 1);
         s_last  = lst;
         if (abort_after >= 0 && b == abort_after + 1) begin
            en = 1'b0;
            s_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (!en) begin
            fin = 1'b1;
            exp_ready = 1'b0;
         end else if (s_valid) begin
            if (b == 0) exp_label = LD'(label);
            else begin
               exp_pix[b-1] = s_data;
               if (b - 1 == NP - 1) begin
                  fin = 1'b1;
                  if (!lst) exp_err = 1'b1;
               end else if (lst) begin
                  fin = 1'b1;
                  exp_err = 1'b1;
               end
            end
            b++;
            if (fin) exp_ready = 1'b0;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (en) begin
         @(posedge clk); #1;
         exp_done = 1'b1;
         if (done) done_cyc = cyc - start_c;
      end
   endtask

   task automatic end_frame();
      en = 1'b0;
      @(posedge clk); #1;
      exp_done = 1'b0;
   endtask

   int dc;

   initial begin
      rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset s_ready", s_ready, 0);
      check("reset done", done, 0);
      check("reset err", err, 0);
      check("reset o_label", o_label, 0);
      check("reset o_image zero", (o_image == '0), 1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_on = 1'b1;

      // Nominal frame.
      send_frame(8'h07, 783, 1'b0, -1, dc);
      check("nominal done latency", dc, 786);
      check("nominal label", o_label, 8'h07);
      check("nominal pixel 29", pix(29), 8'h1D);
      check("nominal pixel 783", pix(783), 8'h0F);
      check_image("nominal image");
      end_frame();

      // Source backpressure: s_valid toggles every cycle.
      send_frame(8'h07, 783, 1'b1, -1, dc);
      check("backpressure done latency", dc, 1570);
      check("backpressure label", o_label, 8'h07);
      check_image("backpressure image");
      end_frame();

      // Early s_last on pixel 99.
      send_frame(8'h09, 99, 1'b0, -1, dc);
      check("early done seen", (dc > 0), 1);
      check("early err", err, 1);
      check("early pixel 99", pix(99), 8'h63);
      check("early pixel 100", pix(100), 8'h00);
      check_image("early image");
      end_frame();

      // s_last never asserted.
      send_frame(8'h2A, -1, 1'b0, -1, dc);
      check("missing-last done seen", (dc > 0), 1);
      check("missing-last err", err, 1);
      check("missing-last pixel 783", pix(783), 8'h0F);
      check_image("missing-last image");
      end_frame();

      // Abort after 300 pixels, then a clean restart.
      send_frame(8'h11, -1, 1'b0, 300, dc);
      check("abort done", done, 0);
      check("abort pixel 299 kept", pix(299), 8'h2B);
      check_image("abort partial image");
      repeat (2) @(posedge clk);
      #1;
      send_frame(8'h03, 783, 1'b0, -1, dc);
      check("restart label", o_label, 8'h03);
      check("restart err", err, 0);
      check("restart done latency", dc, 786);
      check_image("restart image");
      end_frame();

      // Asynchronous reset in the middle of a frame.
      chk_on = 1'b0;
      en = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = 8'h55;
      repeat (6) begin
         @(posedge clk); #1;
         s_data = s_data + 8'h01;
      end
      check("pre-rst label", o_label, 8'h55);
      rst = 1'b1;
      #1;
      check("rst s_ready", s_ready, 0);
      check("rst done", done, 0);
      check("rst err", err, 0);
      check("rst o_label", o_label, 0);
      check("rst o_image zero", (o_image == '0), 1);
      en = 1'b0; s_valid = 1'b0; s_data = '0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post-rst s_ready", s_ready, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
